// File: rtl/control_calculadora.sv
`timescale 1ns/1ps
// Keypad sequencer for es_operacion: builds two decimal operands from digit
// keys, latches the operator, fires one calculation cycle and then holds
// either the result or an error indication until the next key.
module control_calculadora #(
  parameter int ANCHO       = 16,
  parameter int MAX_DIGITOS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tecla_valida,
  input  logic [3:0]       tecla,
  input  logic [ANCHO-1:0] resultado,
  output logic [ANCHO-1:0] numero_1,
  output logic [ANCHO-1:0] numero_2,
  output logic [1:0]       suma_resta,
  output logic             operando_en,
  output logic             igual_en,
  output logic [ANCHO-1:0] display,
  output logic             listo,
  output logic             error
);

  localparam int              CW      = $clog2(MAX_DIGITOS + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_DIGITOS);
  localparam logic [CW-1:0]   CNT_UNO = CW'(1);
  localparam logic [ANCHO-1:0] VAL_ERR = '1;

  localparam logic [3:0] K_SUMA  = 4'hA;
  localparam logic [3:0] K_RESTA = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;
  localparam logic [3:0] K_IGUAL = 4'hE;

  typedef enum logic [2:0] {
    ENTRADA_1 = 3'd0,
    ENTRADA_2 = 3'd1,
    CALCULO   = 3'd2,
    RESULTADO = 3'd3,
    ERROR     = 3'd4
  } estado_t;

  estado_t          estado, estado_n;
  logic [ANCHO-1:0] num1_n, num2_n, res, res_n;
  logic [1:0]       op_n;
  logic [CW-1:0]    cnt1, cnt1_n, cnt2, cnt2_n;

  logic       es_digito, es_op;
  logic [1:0] op_tecla;

  // operand*10 + d, truncated to the datapath width
  function automatic logic [ANCHO-1:0] acumula(input logic [ANCHO-1:0] n,
                                               input logic [3:0] d);
    return (n << 3) + (n << 1) + {{(ANCHO-4){1'b0}}, d};
  endfunction

  assign es_digito = (tecla <= 4'd9);
  assign es_op     = (tecla == K_SUMA) || (tecla == K_RESTA);
  assign op_tecla  = (tecla == K_SUMA) ? 2'd1 : 2'd2;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= ENTRADA_1;
      numero_1   <= '0;
      numero_2   <= '0;
      suma_resta <= 2'd0;
      res        <= '0;
      cnt1       <= '0;
      cnt2       <= '0;
    end else begin
      estado     <= estado_n;
      numero_1   <= num1_n;
      numero_2   <= num2_n;
      suma_resta <= op_n;
      res        <= res_n;
      cnt1       <= cnt1_n;
      cnt2       <= cnt2_n;
    end
  end

  // Next-state / next-datapath decode; keys are dropped during CALCULO so
  // the result sample is never disturbed, even by clear.
  always_comb begin
    estado_n = estado;
    num1_n   = numero_1;
    num2_n   = numero_2;
    op_n     = suma_resta;
    res_n    = res;
    cnt1_n   = cnt1;
    cnt2_n   = cnt2;
    if (tecla_valida && tecla == K_CLEAR && estado != CALCULO) begin
      estado_n = ENTRADA_1;
      num1_n   = '0;
      num2_n   = '0;
      op_n     = 2'd0;
      res_n    = '0;
      cnt1_n   = '0;
      cnt2_n   = '0;
    end else begin
      case (estado)
        ENTRADA_1: if (tecla_valida) begin
          if (es_digito) begin
            if (cnt1 != CNT_MAX) begin
              num1_n = acumula(numero_1, tecla);
              cnt1_n = cnt1 + CNT_UNO;
            end
          end else if (es_op) begin
            op_n     = op_tecla;
            num2_n   = '0;
            cnt2_n   = '0;
            estado_n = ENTRADA_2;
          end
        end
        ENTRADA_2: if (tecla_valida) begin
          if (es_digito) begin
            if (cnt2 != CNT_MAX) begin
              num2_n = acumula(numero_2, tecla);
              cnt2_n = cnt2 + CNT_UNO;
            end
          end else if (es_op) begin
            if (cnt2 == '0) op_n = op_tecla;
          end else if (tecla == K_IGUAL) begin
            estado_n = CALCULO;
          end
        end
        CALCULO: begin
          // an honest 16'hFFFF result is indistinguishable from the error code
          if (resultado == VAL_ERR) begin
            estado_n = ERROR;
          end else begin
            res_n    = resultado;
            estado_n = RESULTADO;
          end
        end
        RESULTADO: if (tecla_valida) begin
          if (es_op) begin
            num1_n   = res;
            op_n     = op_tecla;
            num2_n   = '0;
            cnt2_n   = '0;
            estado_n = ENTRADA_2;
          end else if (es_digito) begin
            num1_n   = {{(ANCHO-4){1'b0}}, tecla};
            cnt1_n   = CNT_UNO;
            op_n     = 2'd0;
            estado_n = ENTRADA_1;
          end
        end
        ERROR: ;
        default: estado_n = ENTRADA_1;
      endcase
    end
  end

  // Status strobes and display selection, decoded from the current state
  always_comb begin
    operando_en = 1'b0;
    igual_en    = 1'b0;
    listo       = 1'b0;
    error       = 1'b0;
    display     = numero_1;
    case (estado)
      ENTRADA_2: display = numero_2;
      CALCULO: begin
        display     = numero_2;
        operando_en = 1'b1;
        igual_en    = 1'b1;
      end
      RESULTADO: begin
        display = res;
        listo   = 1'b1;
      end
      ERROR: begin
        display = VAL_ERR;
        error   = 1'b1;
      end
      default: display = numero_1;
    endcase
  end

endmodule

// File: tb/tb_control_calculadora.sv
`timescale 1ns/1ps
// Randomized + directed bench for control_calculadora with a key-level
// reference model and a behavioural stand-in for es_operacion.
module tb_control_calculadora;

  logic        clk = 1'b0;
  logic        reset;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic [15:0] resultado, numero_1, numero_2, display;
  logic [1:0]  suma_resta;
  logic        operando_en, igual_en, listo, error;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 entry1, 1 entry2, 2 result, 3 error, 4 calculating
  int m_ph, m_a, m_b, m_op, m_r, m_c1, m_c2;

  control_calculadora #(.ANCHO(16), .MAX_DIGITOS(4)) dut (
    .clk(clk), .reset(reset), .tecla_valida(tecla_valida), .tecla(tecla),
    .resultado(resultado), .numero_1(numero_1), .numero_2(numero_2),
    .suma_resta(suma_resta), .operando_en(operando_en), .igual_en(igual_en),
    .display(display), .listo(listo), .error(error)
  );

  always #5 clk = ~clk;

  // saturating add / subtract with 65535 marking over/underflow
  function automatic int calc(input int a, input int b, input int op);
    int s;
    if (op == 1) begin
      s = a + b;
      return (s > 65535) ? 65535 : s;
    end else if (op == 2) begin
      return (a < b) ? 65535 : a - b;
    end
    return 0;
  endfunction

  // es_operacion stand-in
  always_comb resultado = 16'(calc(int'(numero_1), int'(numero_2), int'(suma_resta)));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_r = 0; m_c1 = 0; m_c2 = 0;
  endtask

  function automatic int m_disp();
    case (m_ph)
      0: return m_a;
      1, 4: return m_b;
      2: return m_r;
      default: return 65535;
    endcase
  endfunction

  task automatic model_key(input logic [3:0] k);
    int d;
    d = int'(k);
    if (k == 4'hC) begin model_reset(); return; end
    if (k == 4'hD || k == 4'hF) return;
    case (m_ph)
      0: if (d <= 9) begin
           if (m_c1 < 4) begin m_a = (m_a * 10 + d) % 65536; m_c1++; end
         end else if (k == 4'hA || k == 4'hB) begin
           m_op = (k == 4'hA) ? 1 : 2; m_b = 0; m_c2 = 0; m_ph = 1;
         end
      1: if (d <= 9) begin
           if (m_c2 < 4) begin m_b = (m_b * 10 + d) % 65536; m_c2++; end
         end else if (k == 4'hA || k == 4'hB) begin
           if (m_c2 == 0) m_op = (k == 4'hA) ? 1 : 2;
         end else if (k == 4'hE) begin
           m_ph = 4;
         end
      2: if (k == 4'hA || k == 4'hB) begin
           m_a = m_r; m_op = (k == 4'hA) ? 1 : 2; m_b = 0; m_c2 = 0; m_ph = 1;
         end else if (d <= 9) begin
           m_a = d; m_c1 = 1; m_op = 0; m_ph = 0;
         end
      default: ;
    endcase
  endtask

  task automatic model_calc();
    int r;
    r = calc(m_a, m_b, m_op);
    if (r == 65535) m_ph = 3;
    else begin m_r = r; m_ph = 2; end
  endtask

  task automatic check_all();
    chk("display", display, m_disp());
    chk("listo", listo, (m_ph == 2) ? 1 : 0);
    chk("error", error, (m_ph == 3) ? 1 : 0);
    chk("numero_1", numero_1, m_a);
    chk("numero_2", numero_2, m_b);
    chk("suma_resta", suma_resta, m_op);
    chk("igual_en", igual_en, 0);
    chk("operando_en", operando_en, 0);
  endtask

  task automatic check_calc();
    chk("calc_igual_en", igual_en, 1);
    chk("calc_operando_en", operando_en, 1);
    chk("calc_numero_1", numero_1, m_a);
    chk("calc_numero_2", numero_2, m_b);
    chk("calc_suma_resta", suma_resta, m_op);
    chk("calc_display", display, m_b);
    chk("calc_listo", listo, 0);
    chk("calc_error", error, 0);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk); tecla = k; tecla_valida = 1'b1;
    @(posedge clk); #1 tecla_valida = 1'b0;
    model_key(k);
    if (m_ph == 4) begin
      check_calc();
      @(posedge clk); #1;
      model_calc();
    end
    check_all();
  endtask

  // E followed by a key held into the CALCULO cycle, which must be dropped
  task automatic press_e_then(input logic [3:0] k2);
    @(negedge clk); tecla = 4'hE; tecla_valida = 1'b1;
    @(posedge clk); #1 tecla = k2;
    model_key(4'hE);
    check_calc();
    @(posedge clk); #1 tecla_valida = 1'b0;
    model_calc();
    check_all();
  endtask

  // key held valid for n edges counts as n presses
  task automatic hold(input logic [3:0] k, input int n);
    @(negedge clk); tecla = k; tecla_valida = 1'b1;
    repeat (n) begin @(posedge clk); #1 model_key(k); end
    tecla_valida = 1'b0;
    check_all();
  endtask

  initial begin
    logic [3:0] k;
    int r;
    reset = 1'b1; tecla_valida = 1'b0; tecla = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    @(negedge clk);
    check_all();

    // 12 + 34
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hE);
    chk("tp1_display", display, 46);
    chk("tp1_listo", listo, 1);

    // 5 - 9 underflow, error sticks until clear
    press(4'hC); press(4'h5); press(4'hB); press(4'h9); press(4'hE);
    chk("tp2_error", error, 1);
    chk("tp2_display", display, 16'hFFFF);
    press(4'h7); press(4'hE); press(4'hA);
    chk("tp2_still_error", error, 1);
    press(4'hC);
    chk("tp2_clear_display", display, 0);

    // digit limit
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'h6);
    chk("tp3_numero_1", numero_1, 1234);
    press(4'hA); press(4'h1); press(4'hE);
    chk("tp3_display", display, 1235);

    // chaining, then new entry from result
    press(4'hC); press(4'h1); press(4'h0); press(4'hA); press(4'h5); press(4'hE);
    chk("tp4_first", display, 15);
    press(4'hA); press(4'h3); press(4'hE);
    chk("tp4_chain_n1", numero_1, 15);
    chk("tp4_chain_display", display, 18);
    press(4'h7);
    chk("tp4_new_n1", numero_1, 7);
    chk("tp4_new_op", suma_resta, 0);

    // operator change before/after a digit
    press(4'hC); press(4'h8); press(4'hA); press(4'hB); press(4'h2); press(4'hE);
    chk("tp5_display", display, 6);
    press(4'hC); press(4'h8); press(4'hA); press(4'h2); press(4'hB);
    chk("tp5_op_kept", suma_resta, 1);
    press(4'hE);
    chk("tp5_display2", display, 10);

    // E in ENTRADA_1 and D/F ignored, held key, key during CALCULO dropped
    press(4'hC); press(4'hE); press(4'hD); press(4'h6); press(4'hF);
    hold(4'h3, 2);
    chk("hold_numero_1", numero_1, 633);
    press(4'hB); press(4'h3);
    press_e_then(4'hC);
    chk("calc_drop_display", display, 630);

    // async reset between edges in ENTRADA_2
    press(4'hC); press(4'h4); press(4'hA); press(4'h2);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("async_numero_1", numero_1, 0);
    chk("async_numero_2", numero_2, 0);
    chk("async_suma_resta", suma_resta, 0);
    chk("async_display", display, 0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    press(4'h4); press(4'hA); press(4'h4); press(4'hE);
    chk("tp6_display", display, 8);

    // random key streams
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 60)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
      else if (r < 88) k = 4'hE;
      else if (r < 94) k = 4'hC;
      else             k = ($urandom_range(0, 1) == 0) ? 4'hD : 4'hF;
      press(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_calculadora.md
Name: control_calculadora

Overview:
Keypad-driven sequencer for the calculator's add/subtract unit (es_operacion).
- Accumulates two decimal operands from single-digit key pulses and latches the operator.
- Pulses the unit's enables for one cycle, then captures and holds the result or an error indication.
- Sits between the keypad decoder and es_operacion; drives the display value.

Parameters:
ANCHO, 16, datapath width of operands and result; must equal es_operacion width.
MAX_DIGITOS, 4, maximum decimal digits accepted per operand (extra digits ignored).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
tecla_valida  input  1  one-cycle pulse; tecla is valid this cycle.
tecla  input  4  key code: 0-9 digit, A suma, B resta, C clear, E igual; D/F ignored.
resultado  input  ANCHO  combinational result from es_operacion; 16'hFFFF means overflow/underflow.
numero_1  output  ANCHO  registered operand 1 to es_operacion.
numero_2  output  ANCHO  registered operand 2 to es_operacion.
suma_resta  output  2  registered operator: 0 none, 1 suma, 2 resta.
operando_en  output  1  high in CALCULO only.
igual_en  output  1  high in CALCULO only (exactly one cycle per calculation).
display  output  ANCHO  value to show (see below).
listo  output  1  high in RESULTADO.
error  output  1  high in ERROR.

Behaviour:
- Reset (async, any state):
  - numero_1, numero_2, suma_resta, display and internal result register go to 0.
  - Digit counters cleared; state goes to ENTRADA_1.
  - operando_en, igual_en, listo and error go to 0.
- Key handling:
  - Keys are acted on only at a rising edge with tecla_valida=1.
  - Codes D/F are ignored in all states.
  - Clear (C) in any state behaves as reset, synchronously.
- Digit accumulation:
  - A digit key updates the operand as operand*10 + d, truncated to ANCHO, and increments the counter.
  - When the counter equals MAX_DIGITOS, the digit is ignored.
- ENTRADA_1:
  - Digit: accumulate into numero_1.
  - A/B: suma_resta <= 1 or 2; clear numero_2 and counter 2; go to ENTRADA_2.
  - E: ignored.
- ENTRADA_2:
  - Digit: accumulate into numero_2.
  - A/B: replace suma_resta only while counter 2 = 0, otherwise ignored.
  - E: go to CALCULO; an empty operand counts as 0.
- CALCULO (one cycle, no key accepted):
  - igual_en=1 and operando_en=1.
  - At the next edge, resultado is sampled:
    - == 16'hFFFF: go to ERROR.
    - Otherwise: register the result and go to RESULTADO.
  - A legitimate result of 16'hFFFF is treated as error (decided).
- RESULTADO:
  - listo=1.
  - A/B (chaining): numero_1 <= registered result; suma_resta updated; numero_2 and counter 2 cleared; go to ENTRADA_2.
  - Digit: starts a new calculation with numero_1 <= d, counter 1 = 1, suma_resta <= 0; go to ENTRADA_1.
  - E: ignored.
- ERROR:
  - error=1, display=16'hFFFF.
  - Only C or reset exits, to ENTRADA_1.
- Display:
  - ENTRADA_1 shows numero_1.
  - ENTRADA_2 and CALCULO show numero_2.
  - RESULTADO shows the registered result.
  - ERROR shows 16'hFFFF.
- Latency:
  - E accepted at edge N: igual_en is high from N to N+1.
  - listo/error and display are valid after edge N+1.
- Timing rules:
  - A key arriving during CALCULO is dropped.
  - tecla_valida held high for multiple cycles is treated as multiple presses.
- Unused state encodings recover to ENTRADA_1.

Test Plan:
- Keys 1,2,A,3,4,E -> igual_en one cycle with numero_1=12, numero_2=34, suma_resta=1; then listo=1, display=46.
- Keys 5,B,9,E -> resultado FFFF from es_operacion; error=1, display=FFFF; key 7 ignored; C -> ENTRADA_1, all outputs 0.
- Keys 1,2,3,4,5,6 -> numero_1=1234 (5 and 6 ignored); then A,1,E -> display=1235.
- Chaining: 1,0,A,5,E (display 15), then A,3,E -> numero_1=15, display=18; then digit 7 -> new entry, numero_1=7, suma_resta=0.
- Operator change: 8,A,B,2,E -> suma_resta=2, display=6; operator key after a digit in ENTRADA_2 leaves suma_resta unchanged.
- Reset asserted asynchronously mid-ENTRADA_2 (between edges) -> outputs zero immediately; after release, 4,A,4,E -> display=8.
